systolic_psum_drain: RTL and testbench
======================================

# systolic_psum_drain

Output-side collector for the weight-stationary systolic array. Captures the skewed partial sums leaving the bottom row of PEs and re-aligns all columns into one row. Requantizes each 32-bit accumulation to int8 or int4 with round-half-up and saturation. Buffers rows in a small FIFO behind a valid/ready handshake to the activation/output memory writer, and raises a hold request so the array controller can stall the array before the FIFO overflows.

## Interface
- COLS, 4: array columns
- DATA_WIDTH, 8: output element width
- ACC_WIDTH, 32: partial-sum width
- FIFO_DEPTH, 4: row FIFO depth (power of 2, ≥2)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  array enable; the same signal drives the PEs; gates the skew pipeline
- in_valid  in  1  column 0 psum valid this cycle; column c becomes valid c enabled cycles later
- psum_in  in  COLS*ACC_WIDTH  bottom-row psum_out; column c at bits [c*ACC_WIDTH +: ACC_WIDTH]
- quantize_mode  in  1  0 = int8 saturate, 1 = int4 saturate (sign-extended to 8 bits)
- shift  in  5  arithmetic right-shift amount, 0..31; sampled at the aligned stage
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  COLS*DATA_WIDTH  requantized row, column c at [c*DATA_WIDTH +: DATA_WIDTH]
- hold_req  out  1  FIFO occupancy ≥ FIFO_DEPTH-1
- overflow  out  1  sticky: a row was dropped
- clr_overflow  in  1  clears overflow
- row_count  out  16  rows written into FIFO, wraps at 2^16

## Operation
- De-skew:
  - Column c passes through COLS-1-c registers, which shift only when enable=1.
  - in_valid passes through COLS-1 enabled registers.
  - Column COLS-1 has zero delay.
  - aligned_valid = delayed valid & enable.
- Requant stage is one register, loaded when aligned_valid:
  - Per column, sum = sign-extend(psum, ACC_WIDTH+1) + (shift ? 1<<(shift-1) : 0).
  - Then r = sum >>> shift.
  - Clamp to [-128,127] in int8 mode or [-8,7] in int4 mode, then emit the low 8 bits.
- FIFO write: when the requant register is valid.
  - If the FIFO is full and not popping that cycle, the row is dropped, overflow←1 and row_count is unchanged.
  - A write to a full FIFO in the same cycle as a pop succeeds.
- FIFO read: pop when out_valid & out_ready. out_data is the head and is stable while out_valid & !out_ready.
- overflow: set has priority over clr_overflow in the same cycle.
- Reset mid-operation: all skew, requant and FIFO state is discarded immediately. No partial row is emitted.

## Timing
- Reset values: out_valid=0, out_data=0, hold_req=0, overflow=0, row_count=0; all skew and valid registers 0.
- Latency with enable held at 1:
  - in_valid at cycle T gives aligned_valid at T+COLS-1.
  - The requant register is valid at T+COLS.
  - With an empty FIFO, out_valid rises at T+COLS+1.
- enable=0 freezes the skew pipeline. The requant and FIFO stages keep running, so at most one row is in flight after hold_req rises.
- hold_req is combinational on the registered count, so there is no added latency.
- Back-to-back in_valid gives one row per cycle. Sustained throughput is 1 row/cycle when out_ready=1.

## Structure
- Shared package:
  - requant function (sum, shift, mode) → 8-bit
  - INT8_MAX/MIN and INT4_MAX/MIN constants
  - SHIFT_W=5
- Sub-module psum_drain_fifo: synchronous FIFO, parameters WIDTH and DEPTH, ports push/pop/full/empty/count.
- The top level holds the skew pipeline, requant register, overflow logic and row counter.

## Test plan
- COLS=4, shift=0, int8, out_ready=1. Drive skewed psums {5,-3,127,-128} with in_valid at T. Required: out_data {5,-3,127,-128} with out_valid at T+5, one cycle wide.
- Rounding and saturation, shift=4, int8:
  - psum 24 → 2 (24+8=32, 32>>4=2)
  - psum -24 → -1
  - psum 4096 → 127
  - psum -5000 → -128
  - int4 mode: psum 200 → 0x07, psum -200 → 0xF8
- out_ready=0 with 4 consecutive rows:
  - hold_req is 1 once count=3.
  - The 5th row is dropped and sets overflow; row_count=4.
  - clr_overflow clears it.
  - After out_ready=1, the 4 rows drain in order.
- enable toggling 1,0,1,0 during a skewed row: the row is still aligned correctly, and out_valid is delayed by the number of enable=0 cycles.
- Simultaneous push and pop on a full FIFO: no drop, occupancy stays at 4, row_count increments.
- Assert rst_n low two cycles after in_valid: all outputs return to reset values and no row is emitted after release.

Source files
------------

// File: rtl/systolic_psum_drain_pkg.sv
// Shared types, limits and requantization helpers for the systolic psum drain.
// Sums are carried at SUM_W bits so a rounded accumulation cannot overflow.
package systolic_psum_drain_pkg;

    localparam int SHIFT_W = 5;
    localparam int SUM_W   = 64;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;
    localparam int INT4_MAX = 7;
    localparam int INT4_MIN = -8;

    typedef enum logic {
        QM_INT8 = 1'b0,
        QM_INT4 = 1'b1
    } qmode_e;

    function automatic logic signed [SUM_W-1:0] round_bias(
        input logic [SHIFT_W-1:0] shift
    );
        logic signed [SUM_W-1:0] b;
        b = '0;
        if (shift != '0) begin
            b = SUM_W'(1) << (shift - SHIFT_W'(1));
        end
        return b;
    endfunction

    function automatic logic [7:0] requant(
        input logic signed [SUM_W-1:0] sum,
        input logic [SHIFT_W-1:0]      shift,
        input qmode_e                  mode
    );
        logic signed [SUM_W-1:0] r;
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        r  = sum >>> shift;
        hi = (mode == QM_INT4) ? SUM_W'(INT4_MAX) : SUM_W'(INT8_MAX);
        lo = (mode == QM_INT4) ? SUM_W'(INT4_MIN) : SUM_W'(INT8_MIN);
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r[7:0];
    endfunction

endpackage

// File: rtl/systolic_psum_drain_fifo.sv
// Row FIFO between the requant register and the output memory writer.
// A push to a full FIFO only lands when a pop frees the slot in the same cycle.
module psum_drain_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case (1'b1)
            (do_push & ~do_pop): count_d = count_q + CNT_W'(1);
            (~do_push & do_pop): count_d = count_q - CNT_W'(1);
            default:             count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/systolic_psum_drain.sv
// Re-aligns skewed bottom-row psums, requantizes them and queues whole rows.
// hold_req warns the array controller while one row can still be in flight.
module systolic_psum_drain
    import systolic_psum_drain_pkg::*;
#(
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic [COLS*ACC_WIDTH-1:0]  psum_in,
    input  logic                       quantize_mode,
    input  logic [SHIFT_W-1:0]         shift,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*DATA_WIDTH-1:0] out_data,
    output logic                       hold_req,
    output logic                       overflow,
    input  logic                       clr_overflow,
    output logic [15:0]                row_count
);

    localparam int ROW_W = COLS * DATA_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ACC_WIDTH-1:0] aligned [COLS];
    logic [COLS-2:0]      vld_q, vld_d;
    logic                 aligned_valid;
    logic                 rq_valid_q, rq_valid_d;
    logic [ROW_W-1:0]     rq_data_q, rq_data_d;
    logic                 overflow_q, overflow_d;
    logic [15:0]          row_count_q, row_count_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;

    // Column c lags column COLS-1 by COLS-1-c enabled cycles.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign aligned[c] = psum_in[c*ACC_WIDTH +: ACC_WIDTH];
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] dly_q [D];
            logic [ACC_WIDTH-1:0] dly_d [D];

            always_comb begin
                dly_d = dly_q;
                if (enable) begin
                    dly_d[0] = psum_in[c*ACC_WIDTH +: ACC_WIDTH];
                    for (int k = 1; k < D; k++) begin
                        dly_d[k] = dly_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) begin
                        dly_q[k] <= '0;
                    end
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign aligned[c] = dly_q[D-1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        if (enable) begin
            vld_d[0] = in_valid;
            for (int k = 1; k < COLS - 1; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    assign aligned_valid = vld_q[COLS-2] & enable;

    always_comb begin
        rq_valid_d = aligned_valid;
        rq_data_d  = rq_data_q;
        if (aligned_valid) begin
            for (int c = 0; c < COLS; c++) begin
                rq_data_d[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(requant(
                    SUM_W'($signed(aligned[c])) + round_bias(shift),
                    shift, qmode_e'(quantize_mode)));
            end
        end
    end

    assign pop     = out_valid & out_ready;
    assign push_ok = rq_valid_q & (~fifo_full | pop);
    assign drop    = rq_valid_q & fifo_full & ~pop;

    psum_drain_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop),
        .wdata (rq_data_q),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        overflow_d  = overflow_q;
        row_count_d = row_count_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            row_count_d = row_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            rq_valid_q  <= 1'b0;
            rq_data_q   <= '0;
            overflow_q  <= 1'b0;
            row_count_q <= '0;
        end else begin
            vld_q       <= vld_d;
            rq_valid_q  <= rq_valid_d;
            rq_data_q   <= rq_data_d;
            overflow_q  <= overflow_d;
            row_count_q <= row_count_d;
        end
    end

    assign out_valid = ~fifo_empty;
    assign hold_req  = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
    assign overflow  = overflow_q;
    assign row_count = row_count_q;

endmodule

// File: tb/tb_systolic_psum_drain.sv
// Scoreboard bench for systolic_psum_drain: skewed row driver plus an
// output monitor that pops expected rows whenever a row is accepted.
module tb_systolic_psum_drain;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         in_valid;
    logic [127:0] psum_in;
    logic         quantize_mode;
    logic [4:0]   shift;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         hold_req;
    logic         overflow;
    logic         clr_overflow;
    logic [15:0]  row_count;

    systolic_psum_drain #(
        .COLS       (4),
        .DATA_WIDTH (8),
        .ACC_WIDTH  (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .in_valid      (in_valid),
        .psum_in       (psum_in),
        .quantize_mode (quantize_mode),
        .shift         (shift),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .hold_req      (hold_req),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow),
        .row_count     (row_count)
    );

    always #5 clk = ~clk;

    int           cyc_cnt = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           n_pops = 0;
    int           last_pop_cyc = -1;
    logic [31:0]  sb [$];
    logic [127:0] slot [4];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_row: got %0h expected none",
                             out_data);
                end else begin
                    chk("row_data", out_data, sb.pop_front());
                end
                n_pops++;
                last_pop_cyc = cyc_cnt;
            end else if (sb.size() > 0) begin
                chk("head_stable", out_data, sb[0]);
            end
        end
    end

    function automatic logic [127:0] mk(input int a, input int b,
                                        input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [31:0] ex(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    // One clock of the bottom PE row: column c shows the row launched
    // c enabled cycles ago.
    task automatic cyc(input bit v, input logic [127:0] row, input bit en);
        slot[0] = v ? row : '0;
        in_valid = v;
        enable   = en;
        for (int c = 0; c < 4; c++) begin
            psum_in[c*32 +: 32] = slot[c][c*32 +: 32];
        end
        @(posedge clk);
        #1;
        if (en) begin
            slot[3] = slot[2];
            slot[2] = slot[1];
            slot[1] = slot[0];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) begin
            idle(1);
        end
        idle(2);
        chk("drain_done", 32'(sb.size()), 32'd0);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_hold_req"}, {31'd0, hold_req}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_row_count"}, {16'd0, row_count}, 32'd0);
    endtask

    int T;
    int p0;
    logic [15:0] rc0;

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b1;
        in_valid      = 1'b0;
        psum_in       = '0;
        quantize_mode = 1'b0;
        shift         = 5'd0;
        out_ready     = 1'b1;
        clr_overflow  = 1'b0;
        for (int i = 0; i < 4; i++) slot[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // Basic alignment and latency
        p0 = n_pops;
        T  = cyc_cnt;
        sb.push_back(ex(8'h05, 8'hFD, 8'h7F, 8'h80));
        cyc(1'b1, mk(5, -3, 127, -128), 1'b1);
        idle(8);
        chk("latency", 32'(last_pop_cyc), 32'(T + 5));
        chk("one_wide", 32'(n_pops - p0), 32'd1);

        // Rounding and saturation
        shift = 5'd4;
        sb.push_back(ex(8'h02, 8'hFF, 8'h7F, 8'h80));
        cyc(1'b1, mk(24, -24, 4096, -5000), 1'b1);
        idle(8);
        quantize_mode = 1'b1;
        sb.push_back(ex(8'h07, 8'hF8, 8'h02, 8'hFF));
        cyc(1'b1, mk(200, -200, 24, -24), 1'b1);
        idle(8);
        quantize_mode = 1'b0;
        shift = 5'd1;
        sb.push_back(ex(8'h02, 8'hFF, 8'h01, 8'h00));
        cyc(1'b1, mk(3, -3, 1, -1), 1'b1);
        idle(8);
        shift = 5'd0;

        // Back-to-back rows, one per cycle
        p0 = n_pops;
        T  = cyc_cnt;
        sb.push_back(ex(8'h01, 8'h02, 8'h03, 8'h04));
        cyc(1'b1, mk(1, 2, 3, 4), 1'b1);
        sb.push_back(ex(8'h0A, 8'hF6, 8'h14, 8'hEC));
        cyc(1'b1, mk(10, -10, 20, -20), 1'b1);
        sb.push_back(ex(8'h7F, 8'h80, 8'h00, 8'h64));
        cyc(1'b1, mk(300, -300, 0, 100), 1'b1);
        idle(10);
        chk("b2b_pops", 32'(n_pops - p0), 32'd3);
        chk("b2b_last", 32'(last_pop_cyc), 32'(T + 7));

        // Backpressure, hold_req and overflow
        out_ready = 1'b0;
        rc0 = row_count;
        T   = cyc_cnt;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) sb.push_back(ex(8'(k), 8'(k + 10), 8'(-k - 1), 8'd100));
            cyc(1'b1, mk(k, k + 10, -k - 1, 100), 1'b1);
        end
        idle(1);
        chk("hold_at_2", {31'd0, hold_req}, 32'd0);
        idle(1);
        chk("hold_at_3", {31'd0, hold_req}, 32'd1);
        idle(6);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_row_count", {16'd0, row_count}, {16'd0, rc0 + 16'd4});
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        clr_overflow = 1'b1;
        idle(1);
        clr_overflow = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        drain();
        chk("hold_after_drain", {31'd0, hold_req}, 32'd0);

        // Enable toggling during a skewed row
        T = cyc_cnt;
        sb.push_back(ex(8'h0B, 8'hEA, 8'h21, 8'hD4));
        cyc(1'b1, mk(11, -22, 33, -44), 1'b1);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        idle(8);
        chk("enable_latency", 32'(last_pop_cyc), 32'(T + 7));

        // Push and pop on a full FIFO
        out_ready = 1'b0;
        rc0 = row_count;
        p0  = n_pops;
        for (int k = 0; k < 5; k++) begin
            sb.push_back(ex(8'(k + 40), 8'(k + 50), 8'(k + 60), 8'(k + 70)));
            cyc(1'b1, mk(k + 40, k + 50, k + 60, k + 70), 1'b1);
        end
        idle(3);
        chk("full_hold", {31'd0, hold_req}, 32'd1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(3);
        chk("pp_no_ovf", {31'd0, overflow}, 32'd0);
        chk("pp_row_count", {16'd0, row_count}, {16'd0, rc0 + 16'd5});
        chk("pp_still_full", {31'd0, hold_req}, 32'd1);
        chk("pp_one_pop", 32'(n_pops - p0), 32'd1);
        out_ready = 1'b1;
        drain();

        // Reset in the middle of traffic
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) sb.push_back(ex(8'(k + 1), 8'd0, 8'd0, 8'd0));
            cyc(1'b1, mk(k + 1, 0, 0, 0), 1'b1);
        end
        idle(8);
        chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
        cyc(1'b1, mk(9, 9, 9, 9), 1'b1);
        idle(1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        psum_in  = '0;
        for (int i = 0; i < 4; i++) slot[i] = '0;
        sb.delete();
        #2;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        p0 = n_pops;
        idle(12);
        chk("post_rst_pops", 32'(n_pops - p0), 32'd0);
        chk("post_rst_count", {16'd0, row_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
